// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity codes, FSM encoding and frame-length helper for the UART TX
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // The S_ prefix keeps the state names clear of the PARITY parameter.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  function automatic int frame_len(input int clks_per_bit, input int data_bits,
                                   input int parity, input int stop_bits);
    return clks_per_bit * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period divider; pulses tick on the last clock of each serial bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Held at zero while idle so every bit period starts cleanly on the accept edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter: start, LSB-first data, optional parity, 1/2 stop bits
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be >= 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_idx;
  logic                 par_bit;
  logic                 tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .run   (state != S_IDLE),
    .tick  (tick)
  );

  assign tx_ready = (state == S_IDLE);

  // Parity is fixed at accept time from the latched word, so tx_data may change freely afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (tx_valid) begin
            shreg   <= tx_data;
            par_bit <= (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            tx    <= shreg[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != PAR_NONE) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - scoreboard bench driving four differently parametrised transmitters
module tb_uart_tx_param;

  typedef struct packed {
    logic tx;
    logic busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] data [4];
  logic [3:0] valid;
  wire  [3:0] tx_w;
  wire  [3:0] busy_w;
  wire  [3:0] rdy_w;

  int cpb_a [4] = '{4, 4, 2, 1};
  int db_a  [4] = '{8, 8, 8, 5};
  int par_a [4] = '{2, 1, 0, 0};
  int sb_a  [4] = '{1, 1, 2, 1};

  exp_t q [$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .tx_data(data[0][7:0]), .tx_valid(valid[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .tx_data(data[1][7:0]), .tx_valid(valid[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

  uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset), .tx_data(data[2][7:0]), .tx_valid(valid[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

  uart_tx_param #(.CLKS_PER_BIT(1), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_d (
    .clk(clk), .reset(reset), .tx_data(data[3][4:0]), .tx_valid(valid[3]),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic push_frame(input int k, input logic [8:0] w);
    logic p;
    p = 1'b0;
    repeat (cpb_a[k]) q.push_back('{tx: 1'b0, busy: 1'b1});
    for (int i = 0; i < db_a[k]; i++) begin
      p = p ^ w[i];
      repeat (cpb_a[k]) q.push_back('{tx: w[i], busy: 1'b1});
    end
    if (par_a[k] != 0) begin
      if (par_a[k] == 1) p = ~p;
      repeat (cpb_a[k]) q.push_back('{tx: p, busy: 1'b1});
    end
    repeat (sb_a[k] * cpb_a[k]) q.push_back('{tx: 1'b1, busy: 1'b1});
  endtask

  task automatic push_idle();
    q.push_back('{tx: 1'b1, busy: 1'b0});
  endtask

  task automatic check_cycles(input int k, input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk($sformatf("sb_nonempty u%0d", k), q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk($sformatf("tx u%0d cyc%0d", k, c), tx_w[k], e.tx);
        chk($sformatf("busy u%0d cyc%0d", k, c), busy_w[k], e.busy);
        chk($sformatf("ready u%0d cyc%0d", k, c), rdy_w[k], ~e.busy);
      end
    end
  endtask

  task automatic send(input int k, input logic [8:0] w, input bit hold);
    int waited;
    waited = 0;
    while (rdy_w[k] !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("ready_wait u%0d", k), rdy_w[k], 1'b1);
    data[k]  = w;
    valid[k] = 1'b1;
    push_frame(k, w);
    @(posedge clk);
    if (!hold) #1 valid[k] = 1'b0;
  endtask

  initial begin
    valid = '0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset tx u%0d", k), tx_w[k], 1'b1);
      chk($sformatf("reset busy u%0d", k), busy_w[k], 1'b0);
      chk($sformatf("reset ready u%0d", k), rdy_w[k], 1'b1);
    end
    reset = 1'b1;
    @(negedge clk);

    // 4/8/even, 0xA5
    send(0, 9'h0A5, 1'b0);
    push_idle();
    check_cycles(0, q.size());

    // 4/8/odd, 0x00
    send(1, 9'h000, 1'b0);
    push_idle();
    check_cycles(1, q.size());

    // 2/8/none/2 stop, 0xFF
    send(2, 9'h0FF, 1'b0);
    push_idle();
    check_cycles(2, q.size());

    // tx_valid held: 0x55 then 0x0F, data changed mid-frame
    send(0, 9'h055, 1'b1);
    push_idle();
    push_frame(0, 9'h00F);
    check_cycles(0, 3);
    data[0] = 9'h00F;
    check_cycles(0, 41 + 1 + 5);
    valid[0] = 1'b0;
    data[0]  = 9'h033;
    push_idle();
    check_cycles(0, q.size());

    // reset mid DATA bit 3
    send(0, 9'h0A5, 1'b0);
    check_cycles(0, 4 + 12 + 2);
    #2 reset = 1'b0;
    #1;
    chk("async_reset tx", tx_w[0], 1'b1);
    chk("async_reset busy", busy_w[0], 1'b0);
    chk("async_reset ready", rdy_w[0], 1'b1);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(0, 9'h03C, 1'b0);
    push_idle();
    check_cycles(0, q.size());

    // 1/5/none, 0x13
    send(3, 9'h013, 1'b0);
    push_idle();
    check_cycles(3, q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
